// File: rtl/ula_sequencial_if.sv
// ula_sequencial_if: operand/opcode/handshake bundle between the control
// unit (master) and the sequential ALU (slave).
interface ula_sequencial_if #(
   parameter int LARGURA = 8
);
   logic               inicio;
   logic [2:0]         ULAOp;
   logic [LARGURA-1:0] Entrada1;
   logic [LARGURA-1:0] Entrada2;
   logic [LARGURA-1:0] Resultado;
   logic [LARGURA-1:0] Set;
   logic               Zero;
   logic               Ocupado;
   logic               Pronto;
   logic               Erro;

   modport master (
      output inicio, ULAOp, Entrada1, Entrada2,
      input  Resultado, Set, Zero, Ocupado, Pronto, Erro
   );

   modport slave (
      input  inicio, ULAOp, Entrada1, Entrada2,
      output Resultado, Set, Zero, Ocupado, Pronto, Erro
   );
endinterface

// File: rtl/ula_sequencial.sv
// ula_sequencial: registered ALU with start/busy/done handshake.
// Single-cycle: add, beq, sub, slt. Multi-cycle: shift-add unsigned multiply
// and (when ULA_DIV_EN is defined) restoring unsigned divide, one step per
// clock. Without ULA_DIV_EN, op 111 completes in one cycle with Erro=1.
module ula_sequencial #(
   parameter int LARGURA = 8
) (
   input  logic            clock,
   input  logic            reset,
   ula_sequencial_if.slave bus
);
   localparam int CW = $clog2(LARGURA + 1);

   typedef enum logic {OCIOSO, CALC} estado_t;

   estado_t            r_estado, w_estado;
   logic [CW-1:0]      r_cont, w_cont;
   logic [LARGURA-1:0] r_m, w_m;
   logic [LARGURA-1:0] r_hi, w_hi;
   logic [LARGURA-1:0] r_lo, w_lo;
   logic [LARGURA-1:0] r_res, w_res;
   logic [LARGURA-1:0] r_set, w_set;
   logic               r_zero, w_zero;
   logic               r_erro, w_erro;
   logic               r_ocup, w_ocup;
   logic               r_pronto, w_pronto;

   logic [LARGURA:0]   w_soma;
   logic [LARGURA-1:0] w_it_hi, w_it_lo;

   logic [LARGURA-1:0] w_u_res, w_u_set;
   logic               w_u_zero, w_u_erro, w_u_longo;

`ifdef ULA_DIV_EN
   logic               r_div, w_div, w_u_div;
   logic [LARGURA:0]   w_rem, w_dif;
`endif

   // Decode of the requested op: single-cycle results or long-op request
   always_comb begin
      w_u_res   = '0;
      w_u_set   = '0;
      w_u_zero  = 1'b0;
      w_u_erro  = 1'b0;
      w_u_longo = 1'b0;
`ifdef ULA_DIV_EN
      w_u_div   = 1'b0;
`endif
      case (bus.ULAOp)
         3'b000, 3'b001, 3'b010: w_u_res = bus.Entrada1 + bus.Entrada2;
         3'b011: w_u_zero = (bus.Entrada1 == bus.Entrada2);
         3'b100: begin
            w_u_res  = bus.Entrada1 - bus.Entrada2;
            w_u_zero = (bus.Entrada1 == bus.Entrada2);
         end
         3'b101: w_u_set = {{(LARGURA-1){1'b0}},
                            ($signed(bus.Entrada1) < $signed(bus.Entrada2))};
         3'b110: w_u_longo = 1'b1;
         3'b111: begin
`ifdef ULA_DIV_EN
            if (bus.Entrada2 == '0) begin
               w_u_res  = '1;
               w_u_set  = bus.Entrada1;
               w_u_erro = 1'b1;
            end else begin
               w_u_longo = 1'b1;
               w_u_div   = 1'b1;
            end
`else
            w_u_erro = 1'b1;
`endif
         end
      endcase
   end

   // One iteration step: hi:lo holds product (mul) or remainder:quotient (div)
   always_comb begin
      w_soma  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      w_it_hi = w_soma[LARGURA:1];
      w_it_lo = {w_soma[0], r_lo[LARGURA-1:1]};
`ifdef ULA_DIV_EN
      w_rem = {r_hi, r_lo[LARGURA-1]};
      w_dif = w_rem - {1'b0, r_m};
      if (r_div) begin
         // remainder stays below the divisor, so the top bit of the
         // difference is a clean borrow flag
         if (!w_dif[LARGURA]) begin
            w_it_hi = w_dif[LARGURA-1:0];
            w_it_lo = {r_lo[LARGURA-2:0], 1'b1};
         end else begin
            w_it_hi = w_rem[LARGURA-1:0];
            w_it_lo = {r_lo[LARGURA-2:0], 1'b0};
         end
      end
`endif
   end

   // Next-state and next-output logic
   always_comb begin
      w_estado = r_estado;
      w_cont   = r_cont;
      w_m      = r_m;
      w_hi     = r_hi;
      w_lo     = r_lo;
      w_res    = r_res;
      w_set    = r_set;
      w_zero   = r_zero;
      w_erro   = r_erro;
      w_ocup   = r_ocup;
      w_pronto = 1'b0;
`ifdef ULA_DIV_EN
      w_div    = r_div;
`endif
      case (r_estado)
         OCIOSO: begin
            if (bus.inicio) begin
               if (w_u_longo) begin
                  w_estado = CALC;
                  w_ocup   = 1'b1;
                  w_cont   = CW'(LARGURA);
                  w_hi     = '0;
`ifdef ULA_DIV_EN
                  w_div = w_u_div;
                  w_m   = w_u_div ? bus.Entrada2 : bus.Entrada1;
                  w_lo  = w_u_div ? bus.Entrada1 : bus.Entrada2;
`else
                  w_m   = bus.Entrada1;
                  w_lo  = bus.Entrada2;
`endif
               end else begin
                  w_res    = w_u_res;
                  w_set    = w_u_set;
                  w_zero   = w_u_zero;
                  w_erro   = w_u_erro;
                  w_pronto = 1'b1;
               end
            end
         end
         CALC: begin
            w_hi   = w_it_hi;
            w_lo   = w_it_lo;
            w_cont = r_cont - CW'(1);
            if (r_cont == CW'(1)) begin
               w_estado = OCIOSO;
               w_ocup   = 1'b0;
               w_pronto = 1'b1;
               w_erro   = 1'b0;
               w_res    = w_it_lo;
               w_set    = w_it_hi;
`ifdef ULA_DIV_EN
               w_zero   = r_div ? (w_it_lo == '0)
                                : ((w_it_hi == '0) && (w_it_lo == '0));
`else
               w_zero   = (w_it_hi == '0) && (w_it_lo == '0);
`endif
            end
         end
      endcase
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_estado <= OCIOSO;
      else       r_estado <= w_estado;
   end

   // Datapath and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cont   <= '0;
         r_m      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_res    <= '0;
         r_set    <= '0;
         r_zero   <= 1'b0;
         r_erro   <= 1'b0;
         r_ocup   <= 1'b0;
         r_pronto <= 1'b0;
`ifdef ULA_DIV_EN
         r_div    <= 1'b0;
`endif
      end else begin
         r_cont   <= w_cont;
         r_m      <= w_m;
         r_hi     <= w_hi;
         r_lo     <= w_lo;
         r_res    <= w_res;
         r_set    <= w_set;
         r_zero   <= w_zero;
         r_erro   <= w_erro;
         r_ocup   <= w_ocup;
         r_pronto <= w_pronto;
`ifdef ULA_DIV_EN
         r_div    <= w_div;
`endif
      end
   end

   assign bus.Resultado = r_res;
   assign bus.Set       = r_set;
   assign bus.Zero      = r_zero;
   assign bus.Ocupado   = r_ocup;
   assign bus.Pronto    = r_pronto;
   assign bus.Erro      = r_erro;
endmodule

// File: tb/tb_ula_sequencial.sv
// tb_ula_sequencial: directed scoreboard bench for ula_sequencial (LARGURA=8).
module tb_ula_sequencial;
   localparam int L = 8;

   typedef struct {
      logic [L-1:0] res;
      logic [L-1:0] set;
      logic         zero;
      logic         erro;
      int           lat;
   } esperado_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   falhas = 0;
   esperado_t fila[$];

   ula_sequencial_if #(.LARGURA(L)) bus ();

   ula_sequencial #(.LARGURA(L)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic esperado_t modelo(input logic [2:0] op, input logic [L-1:0] a,
                                        input logic [L-1:0] b);
      esperado_t e;
      logic [2*L-1:0] p;
      e.res = '0; e.set = '0; e.zero = 1'b0; e.erro = 1'b0; e.lat = 0;
      case (op)
         3'd0, 3'd1, 3'd2: e.res = a + b;
         3'd3: e.zero = (a == b);
         3'd4: begin e.res = a - b; e.zero = (a == b); end
         3'd5: e.set = ($signed(a) < $signed(b)) ? L'(1) : L'(0);
         3'd6: begin
            p = a * b;
            e.res = p[L-1:0]; e.set = p[2*L-1:L]; e.zero = (p == '0); e.lat = L;
         end
         3'd7: begin
`ifdef ULA_DIV_EN
            if (b == '0) begin
               e.res = '1; e.set = a; e.erro = 1'b1;
            end else begin
               e.res = a / b; e.set = a % b; e.zero = ((a / b) == '0); e.lat = L;
            end
`else
            e.erro = 1'b1;
`endif
         end
      endcase
      return e;
   endfunction

   task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      assert (obs === esp) else begin
         falhas++;
         $error("FAIL %s observado=%0h esperado=%0h", tag, obs, esp);
      end
   endtask

   task automatic iniciar(input logic [2:0] op, input logic [L-1:0] a,
                          input logic [L-1:0] b, input bit agora);
      if (!agora) @(negedge clock);
      bus.inicio = 1'b1; bus.ULAOp = op; bus.Entrada1 = a; bus.Entrada2 = b;
      fila.push_back(modelo(op, a, b));
      @(posedge clock);
      #1;
      bus.inicio   = 1'b0;
      bus.ULAOp    = 3'($urandom);
      bus.Entrada1 = L'($urandom);
      bus.Entrada2 = L'($urandom);
   endtask

   // Waits for Pronto; optionally pulses an add request on cycle pulso_n
   task automatic esperar_pronto(input string tag, input int pulso_n);
      esperado_t e;
      bit visto = 1'b0;
      int ocup = 0;
      for (int n = 1; n <= 40 && !visto; n++) begin
         @(negedge clock);
         if (n == pulso_n) begin
            bus.inicio = 1'b1; bus.ULAOp = 3'b010; bus.Entrada1 = 8'd1; bus.Entrada2 = 8'd1;
         end else if (n == pulso_n + 1) begin
            bus.inicio = 1'b0;
         end
         if (bus.Ocupado === 1'b1) ocup++;
         if (bus.Pronto === 1'b1) begin
            visto = 1'b1;
            checks++;
            assert (fila.size() > 0) else begin
               falhas++;
               $error("FAIL %s_fila observado=vazia esperado=item", tag);
            end
            if (fila.size() > 0) begin
               e = fila.pop_front();
               checar({tag, "_res"}, 32'(bus.Resultado), 32'(e.res));
               checar({tag, "_set"}, 32'(bus.Set), 32'(e.set));
               checar({tag, "_zero"}, 32'(bus.Zero), 32'(e.zero));
               checar({tag, "_erro"}, 32'(bus.Erro), 32'(e.erro));
               checar({tag, "_lat"}, n - 1, e.lat);
               checar({tag, "_ocup"}, ocup, e.lat);
            end
         end
      end
      if (pulso_n > 0) bus.inicio = 1'b0;
      checks++;
      assert (visto) else begin
         falhas++;
         $error("FAIL %s_timeout observado=sem_pronto esperado=pronto", tag);
      end
   endtask

   task automatic executar(input logic [2:0] op, input logic [L-1:0] a,
                           input logic [L-1:0] b, input string tag);
      iniciar(op, a, b, 1'b0);
      esperar_pronto(tag, -1);
      @(negedge clock);
      checar({tag, "_pulso"}, 32'(bus.Pronto), 32'd0);
   endtask

   initial begin
      int cnt;
      bus.inicio = 1'b0; bus.ULAOp = '0; bus.Entrada1 = '0; bus.Entrada2 = '0;
      repeat (2) @(negedge clock);
      checar("reset", 32'({bus.Resultado, bus.Set, bus.Zero, bus.Ocupado, bus.Pronto, bus.Erro}), 32'd0);
      reset = 1'b0;

      executar(3'b010, 8'd100, 8'd27, "add");
      executar(3'b000, 8'd200, 8'd100, "add_wrap");
      executar(3'b101, 8'hFD, 8'd5, "slt_neg");
      executar(3'b101, 8'd5, 8'hFD, "slt_pos");
      executar(3'b011, 8'h3C, 8'h3C, "beq_eq");
      executar(3'b011, 8'h3C, 8'h3D, "beq_ne");
      executar(3'b100, 8'd50, 8'd80, "sub");
      executar(3'b100, 8'd7, 8'd7, "sub_eq");
      executar(3'b110, 8'd200, 8'd3, "mul");
      executar(3'b110, 8'd255, 8'd255, "mul_max");
      executar(3'b110, 8'd0, 8'd99, "mul_zero");
      executar(3'b111, 8'd100, 8'd7, "div");
      executar(3'b111, 8'd100, 8'd0, "div_b0");
      executar(3'b111, 8'd5, 8'd9, "div_q0");
      executar(3'b111, 8'd255, 8'd1, "div_b1");

      // Request during a busy multiply is ignored, then chained in the Pronto cycle
      iniciar(3'b110, 8'd200, 8'd3, 1'b0);
      esperar_pronto("mul_ocupado", 3);
      iniciar(3'b010, 8'd10, 8'd20, 1'b1);
      esperar_pronto("b2b", -1);
      @(negedge clock);
      checar("b2b_pulso", 32'(bus.Pronto), 32'd0);

      // Asynchronous reset in the middle of a multiply
      iniciar(3'b110, 8'd77, 8'd5, 1'b0);
      repeat (4) @(posedge clock);
      #1;
      checar("rst_ocup_antes", 32'(bus.Ocupado), 32'd1);
      #1 reset = 1'b1;
      #1;
      checar("rst_async", 32'({bus.Resultado, bus.Set, bus.Zero, bus.Ocupado, bus.Pronto, bus.Erro}), 32'd0);
      void'(fila.pop_back());
      @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      repeat (12) begin
         @(negedge clock);
         if (bus.Pronto === 1'b1) cnt++;
      end
      checar("rst_sem_pronto", cnt, 0);
      executar(3'b010, 8'd33, 8'd44, "add_pos_rst");
      checar("fila_vazia", fila.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, falhas);
      $finish;
   end
endmodule
